// File: rtl/icache_if.sv
// Fetch/fill bus between the datapath + memory controller (master) and the instruction cache (slave).
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iwait;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only L1 instruction cache: combinational hit path,
// single-word fill on miss, saturating hit/miss counters.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    icache_if.slave     bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    typedef enum logic {IDLE, FILL} state_t;

    state_t          r_state, w_next;
    logic [SETS-1:0] r_valid;
    logic [TW-1:0]   r_tag  [SETS];
    logic [31:0]     r_data [SETS];
    logic [29:0]     r_miss_addr;
    logic [31:0]     r_hit_count, r_miss_count;

    logic [IW-1:0]   w_index, w_fill_index;
    logic [TW-1:0]   w_tag, w_fill_tag;
    logic            w_hit, w_fill_done, w_count_hit, w_start_fill;

    assign w_index      = bus.imemaddr[IW+1:2];
    assign w_tag        = bus.imemaddr[31:IW+2];
    assign w_fill_index = r_miss_addr[IW-1:0];
    assign w_fill_tag   = r_miss_addr[29:IW];
    assign w_hit        = bus.imemREN & r_valid[w_index] & (r_tag[w_index] == w_tag);

    always_comb begin
        w_next       = r_state;
        bus.ihit     = 1'b0;
        bus.imemload = 32'h0;
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'h0;
        w_fill_done  = 1'b0;
        w_count_hit  = 1'b0;
        w_start_fill = 1'b0;
        case (r_state)
            IDLE: begin
                bus.ihit = w_hit;
                if (w_hit) begin
                    bus.imemload = r_data[w_index];
                    w_count_hit  = 1'b1;
                end else if (bus.imemREN) begin
                    w_start_fill = 1'b1;
                    w_next       = FILL;
                end
            end
            FILL: begin
                // The fill is never cancelled by a redirect; only reset abandons it.
                bus.iREN  = 1'b1;
                bus.iaddr = {r_miss_addr, 2'b00};
                if (!bus.iwait) begin
                    w_fill_done = 1'b1;
                    w_next      = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_miss_addr  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_fill)
                r_miss_addr <= {w_tag, w_index};
            if (w_fill_done)
                r_valid[w_fill_index] <= 1'b1;
            if (w_count_hit && (r_hit_count != 32'hFFFF_FFFF))
                r_hit_count <= r_hit_count + 32'd1;
            if (w_fill_done && (r_miss_count != 32'hFFFF_FFFF))
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    // Tag/data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (w_fill_done) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= bus.iload;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
endmodule

// File: tb/tb_icache.sv
// Bench for icache (SETS=16): directed scenarios then random traffic, all checked
// against a frame-array + pending-fill-queue reference model.
module tb_icache;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] hit_count, miss_count;

    icache_if bus();

    icache #(.SETS(16)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int iren_cycles;

    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic [29:0] m_pending [$];
    logic [31:0] m_hits, m_misses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_pending.delete();
        m_hits   = 32'd0;
        m_misses = 32'd0;
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        return {wa[13:0], wa[17:0]} ^ 32'hA5C3_0F19;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model at the edge.
    task automatic step(input logic ren, input logic [31:0] addr, input logic wt, input logic [31:0] ld);
        logic [3:0]  idx;
        logic [25:0] tg;
        logic        hit;
        logic [29:0] pa;
        bus.imemREN  = ren;
        bus.imemaddr = addr;
        bus.iwait    = wt;
        bus.iload    = ld;
        idx = addr[5:2];
        tg  = addr[31:6];
        hit = ren && (m_pending.size() == 0) && m_valid[idx] && (m_tag[idx] == tg);
        @(negedge CLK);
        if (m_pending.size() == 0) begin
            chk("ihit_idle",     {31'd0, bus.ihit}, {31'd0, hit});
            chk("imemload_idle", bus.imemload, hit ? m_data[idx] : 32'd0);
            chk("iREN_idle",     {31'd0, bus.iREN}, 32'd0);
            chk("iaddr_idle",    bus.iaddr, 32'd0);
        end else begin
            pa = m_pending[0];
            chk("ihit_fill",     {31'd0, bus.ihit}, 32'd0);
            chk("imemload_fill", bus.imemload, 32'd0);
            chk("iREN_fill",     {31'd0, bus.iREN}, 32'd1);
            chk("iaddr_fill",    bus.iaddr, {pa, 2'b00});
        end
        chk("hit_count",  hit_count,  m_hits);
        chk("miss_count", miss_count, m_misses);
        if (bus.iREN === 1'b1) iren_cycles++;
        @(posedge CLK);
        if (m_pending.size() == 0) begin
            if (hit) begin
                if (m_hits != 32'hFFFF_FFFF) m_hits++;
            end else if (ren) begin
                m_pending.push_back(addr[31:2]);
            end
        end else if (!wt) begin
            pa = m_pending.pop_front();
            m_valid[pa[3:0]] = 1'b1;
            m_tag[pa[3:0]]   = pa[29:4];
            m_data[pa[3:0]]  = ld;
            if (m_misses != 32'hFFFF_FFFF) m_misses++;
        end
        #1;
    endtask

    initial begin
        logic [31:0] addr, ld, saved_h, saved_m;
        logic        ren, wt;

        nRST         = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.iwait    = 1'b1;
        bus.iload    = 32'h0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ihit",       {31'd0, bus.ihit}, 32'd0);
        chk("rst_imemload",   bus.imemload, 32'd0);
        chk("rst_iREN",       {31'd0, bus.iREN}, 32'd0);
        chk("rst_iaddr",      bus.iaddr, 32'd0);
        chk("rst_hit_count",  hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        nRST = 1'b1;

        // Cold miss with three wait cycles
        iren_cycles = 0;
        step(1'b1, 32'h40, 1'b1, 32'h0);
        repeat (3) step(1'b1, 32'h40, 1'b1, 32'h0);
        step(1'b1, 32'h40, 1'b0, 32'h8C22_0004);
        chk("cold_iren_cycles", iren_cycles, 32'd4);
        chk("cold_miss_count", miss_count, 32'd1);

        // Repeat hits
        repeat (6) step(1'b1, 32'h40, 1'b0, 32'h0);
        chk("repeat_hit_count", hit_count, 32'd6);
        chk("repeat_iren_cycles", iren_cycles, 32'd4);

        // Conflict in frame 0
        step(1'b1, 32'h80, 1'b0, 32'h0);
        step(1'b1, 32'h80, 1'b0, mem_word(30'h20));
        step(1'b1, 32'h80, 1'b0, 32'h0);
        step(1'b1, 32'h40, 1'b0, 32'h0);
        step(1'b1, 32'h40, 1'b0, 32'h8C22_0004);
        chk("conflict_miss_count", miss_count, 32'd3);
        step(1'b1, 32'h40, 1'b0, 32'h0);

        // Redirect during fill
        step(1'b1, 32'h100, 1'b1, 32'h0);
        step(1'b0, 32'h200, 1'b1, 32'h0);
        step(1'b1, 32'h200, 1'b1, 32'h0);
        step(1'b1, 32'h200, 1'b0, mem_word(30'h40));
        step(1'b1, 32'h100, 1'b0, 32'h0);
        step(1'b1, 32'h200, 1'b0, 32'h0);
        step(1'b1, 32'h200, 1'b0, mem_word(30'h80));
        chk("redirect_miss_count", miss_count, 32'd5);

        // Requests disabled
        saved_h = m_hits;
        saved_m = m_misses;
        for (int i = 0; i < 8; i++)
            step(1'b0, $urandom, 1'(($urandom_range(0, 1))), $urandom);
        chk("noren_hit_count",  hit_count,  saved_h);
        chk("noren_miss_count", miss_count, saved_m);

        // Reset during fill
        step(1'b1, 32'h3C4, 1'b1, 32'h0);
        step(1'b1, 32'h3C4, 1'b1, 32'h0);
        bus.iwait = 1'b0;
        bus.iload = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("pre_reset_iREN", {31'd0, bus.iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("midrst_iREN",       {31'd0, bus.iREN}, 32'd0);
        chk("midrst_iaddr",      bus.iaddr, 32'd0);
        chk("midrst_hit_count",  hit_count, 32'd0);
        chk("midrst_miss_count", miss_count, 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        step(1'b1, 32'h3C4, 1'b1, 32'h0);
        step(1'b1, 32'h3C4, 1'b0, mem_word(30'hF1));
        step(1'b1, 32'h3C4, 1'b0, 32'h0);

        // Random traffic over a small address pool
        addr = 32'h0;
        for (int i = 0; i < 400; i++) begin
            ren = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0)
                addr = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            wt = ($urandom_range(0, 2) == 0);
            ld = (m_pending.size() != 0) ? mem_word(m_pending[0]) : $urandom;
            step(ren, addr, wt, ld);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
